// File: rtl/except_ctrl.sv
// MEM-stage exception controller: picks the highest-priority event, produces the CP0 request and
// the fetch redirect, then ignores new events for a short drain window. Timer interrupt: CPU_TIMER_INT_EN.
module except_ctrl #(
    parameter logic [31:0] VEC_BEV      = 32'hBFC00380,
    parameter logic [31:0] VEC_NORM     = 32'h80000180,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ext_int,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_delayslot,
    input  logic [7:0]  mem_flags,
    input  logic [31:0] mem_badvaddr,
    input  logic [31:0] cp0_status,
    input  logic [1:0]  cp0_cause_ip_sw,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_count,
    input  logic [31:0] cp0_compare,
    input  logic        compare_we,
    output logic [5:0]  hw_ip,
    output logic        flush,
    output logic        eret,
    output logic [4:0]  exc_code,
    output logic [31:0] cur_pc,
    output logic [31:0] badvaddr,
    output logic        delayslot,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic [4:0]  ext_meta, ext_sync;
    logic [5:0]  hw_ip_q;
    logic        timer_pending;
    logic        int_req, take, exc;

    logic unused_status;
    assign unused_status = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta <= '0;
            ext_sync <= '0;
            hw_ip_q  <= '0;
            state    <= IDLE;
            cnt      <= '0;
        end else begin
            ext_meta <= ext_int;
            ext_sync <= ext_meta;
            hw_ip_q  <= hw_ip;
            state    <= state_next;
            cnt      <= cnt_next;
        end
    end

`ifdef CPU_TIMER_INT_EN
    // A Compare write retires the pending timer even if it matches in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                          timer_pending <= 1'b0;
        else if (compare_we)              timer_pending <= 1'b0;
        else if (cp0_count == cp0_compare) timer_pending <= 1'b1;
    end
`else
    logic unused_timer;
    assign unused_timer  = ^{compare_we, cp0_count, cp0_compare};
    assign timer_pending = 1'b0;
`endif

    assign hw_ip = {ext_sync[4] | timer_pending, ext_sync[3:0]};

    // Interrupts use the registered IP copy, so a line is takeable the cycle after it shows in hw_ip.
    assign int_req = cp0_status[0] & ~cp0_status[1] &
                     (|({hw_ip_q, cp0_cause_ip_sw} & cp0_status[15:8]));
    assign take    = mem_valid && (state == IDLE);

    always_comb begin
        flush       = 1'b0;
        eret        = 1'b0;
        exc         = 1'b0;
        exc_code    = 5'd0;
        cur_pc      = 32'd0;
        badvaddr    = 32'd0;
        delayslot   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        state_next  = state;
        cnt_next    = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    exc = 1'b1;
                    if (int_req)           exc_code = 5'd0;
                    else if (mem_flags[1]) begin exc_code = 5'd4; badvaddr = mem_pc; end
                    else if (mem_flags[2]) exc_code = 5'd10;
                    else if (mem_flags[3]) exc_code = 5'd12;
                    else if (mem_flags[4]) exc_code = 5'd8;
                    else if (mem_flags[5]) exc_code = 5'd9;
                    else if (mem_flags[6]) begin exc_code = 5'd4; badvaddr = mem_badvaddr; end
                    else if (mem_flags[7]) begin exc_code = 5'd5; badvaddr = mem_badvaddr; end
                    else begin
                        exc = 1'b0;
                        if (mem_flags[0]) begin
                            eret        = 1'b1;
                            redirect    = 1'b1;
                            redirect_pc = cp0_epc;
                        end
                    end
                    if (exc) begin
                        flush       = 1'b1;
                        redirect    = 1'b1;
                        redirect_pc = cp0_status[22] ? VEC_BEV : VEC_NORM;
                        cur_pc      = mem_pc;
                        delayslot   = mem_delayslot;
                    end
                    if (redirect) begin
                        state_next = DRAIN;
                        cnt_next   = 3'(DRAIN_CYCLES - 1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == 3'd0) state_next = IDLE;
                else             cnt_next   = cnt - 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: priority, drain window, interrupt sync, timer, ERET, reset in drain.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ext_int;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_delayslot;
    logic [7:0]  mem_flags;
    logic [31:0] mem_badvaddr;
    logic [31:0] cp0_status;
    logic [1:0]  cp0_cause_ip_sw;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_count;
    logic [31:0] cp0_compare;
    logic        compare_we;
    logic [5:0]  hw_ip;
    logic        flush, eret, delayslot, redirect;
    logic [4:0]  exc_code;
    logic [31:0] cur_pc, badvaddr, redirect_pc;

    int tests = 0;
    int fails = 0;

`ifdef CPU_TIMER_INT_EN
    localparam logic TIMER_ON = 1'b1;
`else
    localparam logic TIMER_ON = 1'b0;
`endif

    except_ctrl #(.VEC_BEV(32'hBFC00380), .VEC_NORM(32'h80000180), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ext_int(ext_int), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_delayslot(mem_delayslot), .mem_flags(mem_flags), .mem_badvaddr(mem_badvaddr),
        .cp0_status(cp0_status), .cp0_cause_ip_sw(cp0_cause_ip_sw), .cp0_epc(cp0_epc),
        .cp0_count(cp0_count), .cp0_compare(cp0_compare), .compare_we(compare_we),
        .hw_ip(hw_ip), .flush(flush), .eret(eret), .exc_code(exc_code), .cur_pc(cur_pc),
        .badvaddr(badvaddr), .delayslot(delayslot), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ext_int = '0; mem_valid = 1'b0; mem_pc = '0; mem_delayslot = 1'b0;
        mem_flags = '0; mem_badvaddr = '0; cp0_status = '0; cp0_cause_ip_sw = '0;
        cp0_epc = '0; cp0_count = 32'h1; cp0_compare = 32'h0; compare_we = 1'b0;
        tick(); tick();
        #2;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_hw_ip", 32'(hw_ip), 0);

        // Idle with a valid, clean instruction.
        rst = 1'b0; mem_valid = 1'b1; mem_pc = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("idle_flush", 32'(flush), 0);
            chk("idle_redirect", 32'(redirect), 0);
            chk("idle_hw_ip", 32'(hw_ip), 0);
        end

        // ri + ov: ri wins.
        tick();
        mem_flags = 8'h0C; mem_pc = 32'h80001000; mem_delayslot = 1'b1; #2;
        chk("prio_flush", 32'(flush), 1);
        chk("prio_code", 32'(exc_code), 10);
        chk("prio_pc", cur_pc, 32'h80001000);
        chk("prio_ds", 32'(delayslot), 1);
        chk("prio_vec", redirect_pc, 32'h80000180);
        chk("prio_bad", badvaddr, 0);
        tick(); #2;
        chk("prio_one_cycle", 32'(redirect), 0);
        chk("prio_drain_code", 32'(exc_code), 0);
        tick(); mem_valid = 1'b0; mem_flags = '0; mem_delayslot = 1'b0;
        tick();

        // Held syscall: flush at t and t+3 only.
        mem_valid = 1'b1; mem_flags = 8'h10; #2;
        chk("drain_t0", 32'(flush), 1);
        chk("drain_t0_code", 32'(exc_code), 8);
        tick(); #2; chk("drain_t1", 32'(flush), 0);
        tick(); #2; chk("drain_t2", 32'(flush), 0);
        tick(); #2;
        chk("drain_t3", 32'(flush), 1);
        chk("drain_t3_code", 32'(exc_code), 8);
        tick(); mem_valid = 1'b0; mem_flags = '0; tick(); tick();

        // adel_data with bev=1.
        mem_valid = 1'b1; mem_flags = 8'h40; mem_badvaddr = 32'h12345679;
        cp0_status = 32'h00400000; #2;
        chk("adel_code", 32'(exc_code), 4);
        chk("adel_bad", badvaddr, 32'h12345679);
        chk("bev_vec", redirect_pc, 32'hBFC00380);
        tick(); mem_valid = 1'b0; mem_flags = '0; cp0_status = '0; tick(); tick();

        // ext_int[0] with ie=1, im=0x04.
        cp0_status = 32'h00000401; ext_int = 5'h01; mem_pc = 32'h80004000;
        tick(); #2; chk("int_t1_hw_ip", 32'(hw_ip), 0);
        tick(); mem_valid = 1'b1; #2;
        chk("int_t2_hw_ip", 32'(hw_ip), 32'h01);
        chk("int_t2_noflush", 32'(flush), 0);
        tick(); #2;
        chk("int_flush", 32'(flush), 1);
        chk("int_code", 32'(exc_code), 0);
        chk("int_pc", cur_pc, 32'h80004000);
        tick(); mem_valid = 1'b0; tick(); tick();
        cp0_status = 32'h00000403; mem_valid = 1'b1; #2;
        chk("int_exl_noflush", 32'(flush), 0);
        tick(); #2; chk("int_exl_noflush2", 32'(flush), 0);
        mem_valid = 1'b0; ext_int = '0; cp0_status = '0;
        tick(); tick(); tick();

        // Timer pending.
        cp0_count = 32'h100; cp0_compare = 32'h100;
        tick(); cp0_count = 32'h101; #2;
        chk("timer_set", 32'(hw_ip[5]), 32'(TIMER_ON));
        compare_we = 1'b1;
        tick(); compare_we = 1'b0; #2;
        chk("timer_clr", 32'(hw_ip[5]), 0);
        cp0_count = 32'h200; cp0_compare = 32'h200; compare_we = 1'b1;
        tick(); compare_we = 1'b0; cp0_count = 32'h201; #2;
        chk("timer_clr_wins", 32'(hw_ip[5]), 0);

        // ERET, then ERET shadowed by adel_if.
        mem_valid = 1'b1; mem_flags = 8'h01; cp0_epc = 32'h80002004; #2;
        chk("eret", 32'(eret), 1);
        chk("eret_flush", 32'(flush), 0);
        chk("eret_redirect", 32'(redirect), 1);
        chk("eret_pc", redirect_pc, 32'h80002004);
        tick(); #2; chk("eret_drain", 32'(eret), 0);
        mem_valid = 1'b0; tick(); tick();
        mem_valid = 1'b1; mem_flags = 8'h03; mem_pc = 32'h80003000; #2;
        chk("eret_adelif_flush", 32'(flush), 1);
        chk("eret_adelif_code", 32'(exc_code), 4);
        chk("eret_adelif_eret", 32'(eret), 0);
        chk("eret_adelif_bad", badvaddr, 32'h80003000);
        tick(); mem_valid = 1'b0; mem_flags = '0; tick(); tick();

        // Reset while draining.
        mem_valid = 1'b1; mem_flags = 8'h10; #2;
        chk("rdrain_flush", 32'(flush), 1);
        tick(); rst = 1'b1; #2;
        chk("rdrain_in_rst", 32'(flush), 0);
        tick(); rst = 1'b0; #2;
        chk("rdrain_idle", 32'(flush), 1);
        chk("rdrain_code", 32'(exc_code), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
